// File: rtl/board_pkg.sv
// Shared definitions for the board move sequencer.
// Cell encoding is {type[4:0], team}; a board address is {y[2:0], x[2:0]}.
package board_pkg;

    localparam int unsigned CELL_W  = 6;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned COORD_W = 3;
    localparam int unsigned TYPE_W  = 5;

    // Whole-cell codes
    localparam logic [CELL_W-1:0] U_BLANK = 6'b000000;
    localparam logic [CELL_W-1:0] U_NMOVE = 6'b111111;

    // Unit type codes (cell bits [5:1])
    localparam logic [TYPE_W-1:0] U_F = 5'b00001;   // flag
    localparam logic [TYPE_W-1:0] U_N = 5'b11111;   // no-move terrain (lake)

    typedef enum logic [1:0] {
        C_CAPTURE = 2'b00,
        C_DIE     = 2'b01,
        C_TRADE   = 2'b10,
        C_RSVD    = 2'b11
    } cmd_op_e;

    // Latched move command payload
    typedef struct packed {
        cmd_op_e            op;
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] dst_y;
        logic [COORD_W-1:0] dst_x;
    } move_cmd_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] y,
                                                     input logic [COORD_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/board_arbiter.sv
// IDLE-state arbitration of the board RAM port (cmd > place > rd) and the
// renderer read-return pipeline.
// Ports:
//   idle                         sequencer is in IDLE
//   cmd_valid / cmd_ready        command handshake (ready = idle)
//   place_*                      setup write request, written in the grant cycle
//   rd_req / rd_ack              renderer read request and grant
//   rd_valid / rd_data           read return, one cycle after rd_ack
//   place_we, arb_addr, arb_wdata  RAM access requested by the granted client
//   mem_rdata                    RAM read data (one-cycle latency)
module board_arbiter
    import board_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               idle,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               place_valid,
    output logic               place_ready,
    input  logic [COORD_W-1:0] place_x,
    input  logic [COORD_W-1:0] place_y,
    input  logic [CELL_W-1:0]  place_unit,
    input  logic               rd_req,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               rd_ack,
    output logic               rd_valid,
    output logic [CELL_W-1:0]  rd_data,
    output logic               place_we,
    output logic [ADDR_W-1:0]  arb_addr,
    output logic [CELL_W-1:0]  arb_wdata,
    input  logic [CELL_W-1:0]  mem_rdata
);

    logic rd_valid_q;

    // Fixed-priority grant, one client per cycle
    always_comb begin
        cmd_ready   = idle;
        place_ready = idle && !cmd_valid;
        place_we    = place_ready && place_valid;
        rd_ack      = place_ready && !place_valid && rd_req;
        arb_addr    = '0;
        arb_wdata   = U_BLANK;
        if (place_we) begin
            arb_addr  = cell_addr(place_y, place_x);
            arb_wdata = place_unit;
        end else if (rd_ack) begin
            arb_addr  = cell_addr(rd_y, rd_x);
        end
    end

    // Read return marker; RAM data lands the cycle after the grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ack;
        end
    end

    assign rd_valid = rd_valid_q;
    // RAM output is itself registered; gate it so rd_data is zero when idle
    assign rd_data  = rd_valid_q ? mem_rdata : U_BLANK;

endmodule

// File: rtl/board_move_sequencer.sv
// Owns the single-port 64x6 board RAM. Runs move commands as a fixed
// read-modify-write sequence on source and destination cells, and shares
// the RAM with the setup placer and the renderer through board_arbiter.
// Ports:
//   cmd_*        move command handshake, op and coordinates; done/err pulses
//   place_*      setup-phase cell writes
//   rd_*         renderer cell reads
//   mem_*        RAM port (combinational from state and latched operands)
//   win_flag     sticky flag-captured indicator, win_team = capturing team
module board_move_sequencer
    import board_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COORD_W-1:0] src_x,
    input  logic [COORD_W-1:0] src_y,
    input  logic [COORD_W-1:0] dst_x,
    input  logic [COORD_W-1:0] dst_y,
    output logic               cmd_done,
    output logic               cmd_err,
    input  logic               place_valid,
    output logic               place_ready,
    input  logic [COORD_W-1:0] place_x,
    input  logic [COORD_W-1:0] place_y,
    input  logic [CELL_W-1:0]  place_unit,
    input  logic               rd_req,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               rd_ack,
    output logic               rd_valid,
    output logic [CELL_W-1:0]  rd_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [CELL_W-1:0]  mem_wdata,
    output logic               mem_we,
    input  logic [CELL_W-1:0]  mem_rdata,
    output logic               win_flag,
    output logic               win_team
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DST,
        S_CHK,
        S_WR_DST,
        S_WR_SRC,
        S_DONE
    } state_e;

    state_e             state_q;
    move_cmd_t          mv_q;
    logic [CELL_W-1:0]  src_q;
    logic [CELL_W-1:0]  dst_q;
    logic               done_q;
    logic               err_q;
    logic               win_flag_q;
    logic               win_team_q;

    logic               idle;
    logic               place_we;
    logic [ADDR_W-1:0]  arb_addr;
    logic [CELL_W-1:0]  arb_wdata;
    logic [ADDR_W-1:0]  src_addr;
    logic [ADDR_W-1:0]  dst_addr;
    logic               chk_err;
    logic               win_hit;

    assign idle     = (state_q == S_IDLE);
    assign src_addr = cell_addr(mv_q.src_y, mv_q.src_x);
    assign dst_addr = cell_addr(mv_q.dst_y, mv_q.dst_x);

    board_arbiter u_arb (
        .clk         (clk),
        .resetn      (resetn),
        .idle        (idle),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .place_valid (place_valid),
        .place_ready (place_ready),
        .place_x     (place_x),
        .place_y     (place_y),
        .place_unit  (place_unit),
        .rd_req      (rd_req),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .place_we    (place_we),
        .arb_addr    (arb_addr),
        .arb_wdata   (arb_wdata),
        .mem_rdata   (mem_rdata)
    );

    // In CHK the destination cell is still on mem_rdata, so it is checked directly
    assign chk_err = (src_q == U_BLANK) || (src_q == U_NMOVE) ||
                     (mem_rdata == U_NMOVE) || (src_addr == dst_addr) ||
                     (mv_q.op == C_RSVD);

    assign win_hit = (mv_q.op == C_CAPTURE) && (dst_q[CELL_W-1:1] == U_F) &&
                     (dst_q != U_BLANK);

    // Sequencer FSM with its registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            mv_q       <= '0;
            src_q      <= U_BLANK;
            dst_q      <= U_BLANK;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            win_flag_q <= 1'b0;
            win_team_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mv_q    <= '{op:    cmd_op_e'(cmd_op),
                                     src_y: src_y, src_x: src_x,
                                     dst_y: dst_y, dst_x: dst_x};
                        state_q <= S_RD_SRC;
                    end
                end
                S_RD_SRC: state_q <= S_RD_DST;
                S_RD_DST: begin
                    src_q   <= mem_rdata;
                    state_q <= S_CHK;
                end
                S_CHK: begin
                    dst_q <= mem_rdata;
                    if (chk_err) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WR_DST;
                    end
                end
                S_WR_DST: begin
                    // First flag capture wins; later captures leave the team alone
                    if (win_hit && !win_flag_q) begin
                        win_flag_q <= 1'b1;
                        win_team_q <= src_q[0];
                    end
                    state_q <= S_WR_SRC;
                end
                S_WR_SRC: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // RAM port mux: arbiter owns it in IDLE, the sequence owns it otherwise
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = U_BLANK;
        case (state_q)
            S_IDLE: begin
                mem_we    = place_we;
                mem_addr  = arb_addr;
                mem_wdata = arb_wdata;
            end
            S_RD_SRC: mem_addr = src_addr;
            S_RD_DST: mem_addr = dst_addr;
            S_WR_DST: begin
                mem_addr  = dst_addr;
                mem_we    = (mv_q.op != C_DIE);
                mem_wdata = (mv_q.op == C_CAPTURE) ? src_q : U_BLANK;
            end
            S_WR_SRC: begin
                mem_addr  = src_addr;
                mem_we    = 1'b1;
                mem_wdata = U_BLANK;
            end
            default: ;
        endcase
    end

    assign cmd_done = done_q;
    assign cmd_err  = err_q;
    assign win_flag = win_flag_q;
    assign win_team = win_team_q;

endmodule

// File: doc/board_move_sequencer.md
Name: board_move_sequencer

Overview:
- Owns the single-port 64x6 board RAM and shares it between three requesters: the game-control move command, the setup-phase piece placer, and the VGA renderer's cell reader.
- Executes a resolved move command (capture / die / trade) as a fixed read-modify-write sequence on the source and destination cells.
- Flags illegal targets and latches a win when a flag is captured.

Parameters:
- CELL_W, 6, bits per board cell, encoded as {type[4:0], team}.
- ADDR_W, 6, RAM address width; addr = {y[2:0], x[2:0]}, i.e. y*8+x.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  move command request, held until accepted
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 CAPTURE, 01 DIE, 10 TRADE, 11 reserved
- src_x, src_y  in  3 each  moving piece coordinate
- dst_x, dst_y  in  3 each  target coordinate
- cmd_done  out  1  one-cycle pulse when the sequence ends, success or error
- cmd_err  out  1  one-cycle pulse with cmd_done when the command was rejected
- place_valid  in  1  setup write request
- place_ready  out  1  IDLE && !cmd_valid
- place_x, place_y  in  3 each  placement cell
- place_unit  in  6  unit code to write
- rd_req  in  1  renderer read request, held until rd_ack
- rd_x, rd_y  in  3 each  cell to read
- rd_ack  out  1  request granted this cycle
- rd_valid  out  1  rd_data valid, exactly one cycle after rd_ack
- rd_data  out  6  cell contents
- mem_addr  out  6  RAM address
- mem_wdata  out  6  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  6  RAM read data, one-cycle synchronous latency
- win_flag  out  1  sticky; set when a flag is captured
- win_team  out  1  team bit of the capturing piece

Behaviour:
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cmd_done 0, cmd_err 0, rd_ack 0, rd_valid 0, rd_data 0, win_flag 0, win_team 0.
- Reset is asynchronous. Reset mid-sequence aborts to IDLE with no further writes. RAM contents are not cleared.
- Unit codes: BLANK = 6'b000000, NMOVE (lake) = 6'b111111, flag type = 5'b00001.
- Arbitration in IDLE, fixed priority cmd > place > rd, one grant per cycle.
  - cmd accepted when cmd_valid && cmd_ready.
  - place write happens in the grant cycle: mem_we=1, addr={place_y,place_x}, wdata=place_unit. No state change.
  - rd grant: rd_ack=1, mem_addr={rd_y,rd_x}. The next cycle gives rd_valid=1 and rd_data=mem_rdata.
  - Outside IDLE: rd_ack=0, place_ready=0, cmd_ready=0.
- FSM states: IDLE, RD_SRC, RD_DST, CHK, WR_DST, WR_SRC, DONE.
  - IDLE -> RD_SRC on cmd accept. Latch op and coordinates.
  - RD_SRC: mem_addr=src. -> RD_DST.
  - RD_DST: mem_addr=dst; latch mem_rdata as src_q. -> CHK.
  - CHK: latch mem_rdata as dst_q.
    - Error if src_q is BLANK or NMOVE, dst_q is NMOVE, src==dst, or op=11. Error goes -> DONE with err set.
    - Otherwise -> WR_DST.
  - WR_DST: mem_we=1, addr=dst.
    - CAPTURE writes src_q; DIE leaves the RAM unchanged (mem_we=0); TRADE writes BLANK.
    - If CAPTURE and dst_q[5:1]==flag type and dst_q!=BLANK: set win_flag and win_team=src_q[0].
    - -> WR_SRC.
  - WR_SRC: mem_we=1, addr=src, wdata=BLANK for all three ops. -> DONE.
  - DONE: cmd_done=1 and cmd_err as decided in CHK. -> IDLE.
- Latency: accept at edge T; success gives cmd_done high in cycle T+5, and cmd_ready returns in cycle T+6. Error gives cmd_done in cycle T+3.
- mem_* outputs are combinational from the registered state and latched operands. rd_valid and rd_data are registered.
- win_flag stays set until reset; later captures do not change win_team.
- Simultaneous cmd_valid and rd_req in IDLE: the command wins; the renderer keeps rd_req asserted and is served after DONE.

Decomposition:
- Shared package board_pkg: unit codes (U_F..U_N, U_BLANK, U_NMOVE), command codes C_CAPTURE/C_DIE/C_TRADE, CELL_W, coordinate-to-address function.
- One sub-module board_arbiter: the IDLE-state priority grant and read-return pipeline. The sequencer FSM lives in the top module.

Test Plan:
- CAPTURE src(1,2)=6'b001101, dst(1,3)=6'b000000 -> writes addr 25<=001101, then addr 17<=000000; cmd_done at T+5, cmd_err=0.
- TRADE src(0,0)=6'b001110, dst(1,0)=6'b001111 -> addr 1<=000000, addr 0<=000000; win_flag stays 0.
- CAPTURE onto flag: src=6'b010101, dst=6'b000010 -> dst<=010101, win_flag=1, win_team=1; a second capture leaves win_team unchanged.
- Error paths: dst=6'b111111 lake, then src=BLANK -> no mem_we in any cycle, cmd_done and cmd_err pulse at T+3.
- Arbitration: cmd_valid, place_valid and rd_req all high in one IDLE cycle -> cmd served first; place written at T+6; rd_ack in the cycle after that; rd_valid with the correct data one cycle after rd_ack.
- Reset asserted during WR_DST -> mem_we drops immediately; state is IDLE after release; src cell unchanged; cmd_done never pulses.
